gemm_host_sequencer: RTL and testbench

//   Host-side sequencer directly upstream/downstream of gemm_accelerator_top.

---
 rtl/gemm_host_sequencer_if.sv | 47 ++++
 rtl/gemm_host_sequencer.sv | 146 ++++++++++++++
 tb/tb_gemm_host_sequencer.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gemm_host_sequencer_if.sv
// gemm_host_sequencer_if
//   Bundles every non-clock/reset signal of gemm_host_sequencer:
//     command/status : cmd_start, busy, job_done, job_err
//     input stream   : in_valid, in_ready, in_data  (N*DW-bit rows)
//     output stream  : out_valid, out_ready, out_data
//     accelerator    : we_a/addr_a/wdata_a, we_b/addr_b/wdata_b,
//                      start_accel, done_accel, addr_c, rdata_c
//   modport master : the sequencer's view.
//   modport slave  : host + accelerator side (testbench / integration).
interface gemm_host_sequencer_if #(
    parameter int N  = 2,
    parameter int DW = 16,
    parameter int AW = 8
);
    logic              cmd_start;
    logic              busy;
    logic              job_done;
    logic              job_err;
    logic              in_valid;
    logic              in_ready;
    logic [N*DW-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [N*DW-1:0]   out_data;
    logic              we_a;
    logic [AW-1:0]     addr_a;
    logic [N*DW-1:0]   wdata_a;
    logic              we_b;
    logic [AW-1:0]     addr_b;
    logic [N*DW-1:0]   wdata_b;
    logic              start_accel;
    logic              done_accel;
    logic [AW-1:0]     addr_c;
    logic [N*DW-1:0]   rdata_c;

    modport master (
        input  cmd_start, in_valid, in_data, out_ready, done_accel, rdata_c,
        output busy, job_done, job_err, in_ready, out_valid, out_data,
               we_a, addr_a, wdata_a, we_b, addr_b, wdata_b, start_accel, addr_c
    );

    modport slave (
        output cmd_start, in_valid, in_data, out_ready, done_accel, rdata_c,
        input  busy, job_done, job_err, in_ready, out_valid, out_data,
               we_a, addr_a, wdata_a, we_b, addr_b, wdata_b, start_accel, addr_c
    );
endinterface

// File: rtl/gemm_host_sequencer.sv
// gemm_host_sequencer
//   Runs one GEMM job on the accelerator per cmd_start: streams N B-rows then
//   N A-rows into the accelerator buffers, pulses start_accel, waits for
//   done_accel (bounded by TMO_CYC cycles), then reads the N C-rows back and
//   emits them on a valid/ready stream.
// Ports
//   clk  : clock
//   rst  : synchronous reset, active-high
//   bus  : gemm_host_sequencer_if.master (command/status, in/out streams,
//          accelerator buffer and control signals)
module gemm_host_sequencer #(
    parameter int N       = 2,
    parameter int DW      = 16,
    parameter int AW      = 8,
    parameter int TMO_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    gemm_host_sequencer_if.master bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(TMO_CYC + 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(N - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD_B, LOAD_A, START, WAIT, RD_REQ, RD_CAP, FIN
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] row_cnt, cnt_next;
    logic [TW-1:0] tmo_cnt;
    logic          beat;
    logic          out_hs;
    logic          tmo_expire;

    // Handshake-visible outputs are pure functions of state.
    assign bus.in_ready = (state == LOAD_B) || (state == LOAD_A);
    assign bus.busy     = (state != IDLE) && (state != FIN);
    assign bus.job_done = (state == FIN);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        cnt_next   = row_cnt;
        beat       = bus.in_valid && bus.in_ready;
        out_hs     = bus.out_valid && bus.out_ready;
        tmo_expire = (state == WAIT) && !bus.done_accel && (tmo_cnt == TMO_LAST);

        case (state)
            IDLE: if (bus.cmd_start) begin
                state_next = LOAD_B;
                cnt_next   = '0;
            end
            LOAD_B, LOAD_A: if (beat) begin
                if (row_cnt == ROW_LAST) begin
                    cnt_next   = '0;
                    state_next = (state == LOAD_B) ? LOAD_A : START;
                end else begin
                    cnt_next = row_cnt + CW'(1);
                end
            end
            START: state_next = WAIT;
            WAIT: begin
                if (bus.done_accel) begin
                    state_next = RD_REQ;
                    cnt_next   = '0;
                end else if (tmo_expire) begin
                    state_next = IDLE;
                end
            end
            RD_REQ: state_next = RD_CAP;
            RD_CAP: if (out_hs) begin
                if (row_cnt == ROW_LAST) begin
                    state_next = FIN;
                    cnt_next   = '0;
                end else begin
                    state_next = RD_REQ;
                    cnt_next   = row_cnt + CW'(1);
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            row_cnt         <= '0;
            tmo_cnt         <= '0;
            bus.job_err     <= 1'b0;
            bus.start_accel <= 1'b0;
            bus.we_a        <= 1'b0;
            bus.addr_a      <= '0;
            bus.wdata_a     <= '0;
            bus.we_b        <= 1'b0;
            bus.addr_b      <= '0;
            bus.wdata_b     <= '0;
            bus.addr_c      <= '0;
            bus.out_valid   <= 1'b0;
            bus.out_data    <= '0;
        end else begin
            state   <= state_next;
            row_cnt <= cnt_next;

            // Counts consecutive WAIT cycles; cleared whenever WAIT is left.
            tmo_cnt <= ((state == WAIT) && (state_next == WAIT)) ? tmo_cnt + TW'(1) : '0;

            if ((state == IDLE) && bus.cmd_start) begin
                bus.job_err <= 1'b0;
            end else if (tmo_expire) begin
                bus.job_err <= 1'b1;
            end

            // Registered from START so the pulse lands after the last A write
            // (presented during START) has been committed.
            bus.start_accel <= (state == START);

            bus.we_b <= beat && (state == LOAD_B);
            if (beat && (state == LOAD_B)) begin
                bus.addr_b  <= AW'(row_cnt);
                bus.wdata_b <= bus.in_data;
            end
            bus.we_a <= beat && (state == LOAD_A);
            if (beat && (state == LOAD_A)) begin
                bus.addr_a  <= AW'(row_cnt);
                bus.wdata_a <= bus.in_data;
            end

            // Address is set on entry to RD_REQ so read data is valid by RD_CAP.
            if (state_next == RD_REQ) begin
                bus.addr_c <= AW'(cnt_next);
            end

            // Output register: filled once per RD_CAP visit, held until taken.
            if ((state == RD_CAP) && !bus.out_valid) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= bus.rdata_c;
            end else if (out_hs) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_gemm_host_sequencer.sv
module tb_gemm_host_sequencer;
    localparam int N       = 2;
    localparam int DW      = 16;
    localparam int AW      = 8;
    localparam int TMO_CYC = 1024;
    localparam int RW      = N * DW;
    localparam int DELAY   = 6;

    localparam logic [RW-1:0] B0 = 32'h0008_0007;  // B row N-1, goes to addr_b 0
    localparam logic [RW-1:0] B1 = 32'h0006_0005;  // B row 0,   goes to addr_b 1
    localparam logic [RW-1:0] A0 = 32'h0002_0001;
    localparam logic [RW-1:0] A1 = 32'h0004_0003;
    localparam logic [RW-1:0] C0 = 32'h0016_0013;
    localparam logic [RW-1:0] C1 = 32'h0032_002B;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gemm_host_sequencer_if #(.N(N), .DW(DW), .AW(AW)) bus ();

    gemm_host_sequencer #(.N(N), .DW(DW), .AW(AW), .TMO_CYC(TMO_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- accelerator stub ----------------
    logic [RW-1:0]    a_mem [0:(1<<AW)-1];
    logic [RW-1:0]    b_mem [0:(1<<AW)-1];
    logic [RW-1:0]    c_mem [0:(1<<AW)-1];
    logic [AW+RW-1:0] log_a [$];
    logic [AW+RW-1:0] log_b [$];
    int               acc_cnt;
    bit               stub_en = 1'b1;
    int               done_cnt  = 0;
    int               start_cnt = 0;

    // B buffer address k holds matrix row N-1-k.
    function automatic logic [RW-1:0] c_row(input int i);
        logic [RW-1:0] r;
        logic [DW-1:0] s;
        r = '0;
        for (int j = 0; j < N; j++) begin
            s = '0;
            for (int k = 0; k < N; k++)
                s = s + a_mem[i][k*DW +: DW] * b_mem[N-1-k][j*DW +: DW];
            r[j*DW +: DW] = s;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            bus.done_accel <= 1'b0;
            acc_cnt        <= 0;
        end else begin
            bus.done_accel <= 1'b0;
            if (bus.we_a) begin
                a_mem[bus.addr_a] <= bus.wdata_a;
                log_a.push_back({bus.addr_a, bus.wdata_a});
            end
            if (bus.we_b) begin
                b_mem[bus.addr_b] <= bus.wdata_b;
                log_b.push_back({bus.addr_b, bus.wdata_b});
            end
            if (bus.start_accel && stub_en) begin
                acc_cnt <= DELAY;
            end else if (acc_cnt != 0) begin
                acc_cnt <= acc_cnt - 1;
                if (acc_cnt == 1) begin
                    for (int i = 0; i < N; i++) c_mem[i] <= c_row(i);
                    bus.done_accel <= 1'b1;
                end
            end
        end
        bus.rdata_c <= c_mem[bus.addr_c];
        if (bus.job_done)    done_cnt  <= done_cnt + 1;
        if (bus.start_accel) start_cnt <= start_cnt + 1;
    end

    logic [3*RW+3*AW+8-1:0] all_out;
    assign all_out = {bus.busy, bus.job_done, bus.job_err, bus.in_ready, bus.out_valid,
                      bus.out_data, bus.we_a, bus.addr_a, bus.wdata_a, bus.we_b,
                      bus.addr_b, bus.wdata_b, bus.start_accel, bus.addr_c};

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job();
        bus.cmd_start = 1'b1;
        tick();
        bus.cmd_start = 1'b0;
    endtask

    task automatic send_row(input logic [RW-1:0] d, input bit gap);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && t < 100) begin
            tick();
            t++;
        end
        tick();
        bus.in_valid = 1'b0;
        if (gap) tick();
        checks++;
        if (t >= 100) begin
            failures++;
            $display("FAIL send_row: in_ready never rose (waited %0d cycles, limit 100)", t);
        end
    endtask

    task automatic load_all(input bit gap);
        send_row(B0, gap);
        send_row(B1, gap);
        send_row(A0, gap);
        send_row(A1, gap);
    endtask

    task automatic get_row(output logic [RW-1:0] d);
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.out_valid && t < 3000) begin
            @(negedge clk);
            t++;
        end
        d = bus.out_data;
        checks++;
        if (t >= 3000) begin
            failures++;
            $display("FAIL get_row: out_valid never rose (waited %0d cycles, limit 3000)", t);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start_accel();
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.start_accel && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 100) begin
            failures++;
            $display("FAIL wait_start_accel: no pulse within %0d cycles", t);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL reset_power_on: outputs=%h expected 0", all_out);
        end
        tick();
        start_job();
        send_row(B0, 1'b0);
        send_row(B1, 1'b0);
        send_row(A0, 1'b0);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.we_a !== 1'b1) begin
            failures++;
            $display("FAIL reset_setup: in_ready=%b we_a=%b expected 1 1 in LOAD_A",
                     bus.in_ready, bus.we_a);
        end
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL reset_mid_load: outputs=%h expected 0", all_out);
        end
        rst = 1'b0;
        repeat (2) tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: in_ready=%b busy=%b expected 0 0", bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_job();
        logic [RW-1:0] r0, r1;
        int s0, d0, la, lb;
        s0 = start_cnt; d0 = done_cnt; la = log_a.size(); lb = log_b.size();
        start_job();
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL job_busy: busy=%b expected 1", bus.busy);
        end
        load_all(1'b0);
        get_row(r0);
        get_row(r1);
        repeat (3) tick();
        checks++;
        if (r0 !== C0) begin
            failures++;
            $display("FAIL job_row0: got %h expected %h", r0, C0);
        end
        checks++;
        if (r1 !== C1) begin
            failures++;
            $display("FAIL job_row1: got %h expected %h", r1, C1);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL job_done_pulse: %0d cycles high expected 1", done_cnt - d0);
        end
        checks++;
        if (start_cnt - s0 != 1) begin
            failures++;
            $display("FAIL job_start_pulse: %0d cycles high expected 1", start_cnt - s0);
        end
        checks++;
        if (log_b.size() - lb != 2 || log_a.size() - la != 2) begin
            failures++;
            $display("FAIL job_write_count: b=%0d a=%0d expected 2 2",
                     log_b.size() - lb, log_a.size() - la);
        end else begin
            checks++;
            if (log_b[lb] !== {8'd0, B0} || log_b[lb+1] !== {8'd1, B1}) begin
                failures++;
                $display("FAIL job_b_writes: got %h %h expected %h %h",
                         log_b[lb], log_b[lb+1], {8'd0, B0}, {8'd1, B1});
            end
            checks++;
            if (log_a[la] !== {8'd0, A0} || log_a[la+1] !== {8'd1, A1}) begin
                failures++;
                $display("FAIL job_a_writes: got %h %h expected %h %h",
                         log_a[la], log_a[la+1], {8'd0, A0}, {8'd1, A1});
            end
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.job_err !== 1'b0) begin
            failures++;
            $display("FAIL job_end_status: busy=%b job_err=%b expected 0 0", bus.busy, bus.job_err);
        end
    endtask

    task automatic test_input_gaps();
        logic [RW-1:0] r0, r1;
        int la, lb;
        la = log_a.size(); lb = log_b.size();
        start_job();
        load_all(1'b1);
        get_row(r0);
        get_row(r1);
        repeat (3) tick();
        checks++;
        if (r0 !== C0 || r1 !== C1) begin
            failures++;
            $display("FAIL gaps_rows: got %h %h expected %h %h", r0, r1, C0, C1);
        end
        checks++;
        if (log_b.size() - lb != 2 || log_a.size() - la != 2) begin
            failures++;
            $display("FAIL gaps_write_count: b=%0d a=%0d expected 2 2",
                     log_b.size() - lb, log_a.size() - la);
        end else begin
            checks++;
            if (log_b[lb] !== {8'd0, B0} || log_b[lb+1] !== {8'd1, B1} ||
                log_a[la] !== {8'd0, A0} || log_a[la+1] !== {8'd1, A1}) begin
                failures++;
                $display("FAIL gaps_writes: b %h %h a %h %h expected b %h %h a %h %h",
                         log_b[lb], log_b[lb+1], log_a[la], log_a[la+1],
                         {8'd0, B0}, {8'd1, B1}, {8'd0, A0}, {8'd1, A1});
            end
        end
    endtask

    task automatic test_backpressure();
        logic [RW-1:0] r1;
        int t, d0;
        d0 = done_cnt;
        bus.out_ready = 1'b0;
        start_job();
        load_all(1'b0);
        t = 0;
        @(negedge clk);
        while (!bus.out_valid && t < 3000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== C0) begin
            failures++;
            $display("FAIL bp_first_row: valid=%b data=%h expected 1 %h", bus.out_valid, bus.out_data, C0);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== C0 || bus.addr_c !== 8'd0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%h addr_c=%0d expected 1 %h 0",
                         i, bus.out_valid, bus.out_data, bus.addr_c, C0);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: out_valid=%b expected 0 after handshake", bus.out_valid);
        end
        get_row(r1);
        repeat (3) tick();
        checks++;
        if (r1 !== C1 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL bp_row1: data=%h done=%0d expected %h 1", r1, done_cnt - d0, C1);
        end
    endtask

    task automatic test_lost_done();
        logic [RW-1:0] r0, r1;
        int n, d0;
        d0 = done_cnt;
        stub_en = 1'b0;
        start_job();
        load_all(1'b0);
        wait_start_accel();
        n = 0;
        while (!bus.job_err && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != TMO_CYC) begin
            failures++;
            $display("FAIL tmo_cycles: job_err after %0d WAIT cycles expected %0d", n, TMO_CYC);
        end
        checks++;
        if (bus.job_err !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL tmo_status: job_err=%b busy=%b out_valid=%b expected 1 0 0",
                     bus.job_err, bus.busy, bus.out_valid);
        end
        repeat (3) tick();
        checks++;
        if (bus.job_err !== 1'b1 || done_cnt != d0) begin
            failures++;
            $display("FAIL tmo_sticky: job_err=%b job_done pulses=%0d expected 1 0",
                     bus.job_err, done_cnt - d0);
        end
        stub_en = 1'b1;
        start_job();
        checks++;
        if (bus.job_err !== 1'b0) begin
            failures++;
            $display("FAIL tmo_clear: job_err=%b expected 0 after cmd_start", bus.job_err);
        end
        load_all(1'b0);
        get_row(r0);
        get_row(r1);
        repeat (3) tick();
        checks++;
        if (r0 !== C0 || r1 !== C1 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL tmo_recover: rows %h %h done=%0d expected %h %h 1",
                     r0, r1, done_cnt - d0, C0, C1);
        end
    endtask

    task automatic test_cmd_repeat();
        logic [RW-1:0] r0, r1;
        int s0, d0;
        s0 = start_cnt; d0 = done_cnt;
        start_job();
        load_all(1'b0);
        wait_start_accel();
        @(posedge clk);
        #1;
        bus.cmd_start = 1'b1;
        repeat (4) tick();
        bus.cmd_start = 1'b0;
        get_row(r0);
        get_row(r1);
        repeat (5) tick();
        checks++;
        if (r0 !== C0 || r1 !== C1) begin
            failures++;
            $display("FAIL repeat_rows: got %h %h expected %h %h", r0, r1, C0, C1);
        end
        checks++;
        if (done_cnt - d0 != 1 || start_cnt - s0 != 1) begin
            failures++;
            $display("FAIL repeat_pulses: job_done=%0d start_accel=%0d expected 1 1",
                     done_cnt - d0, start_cnt - s0);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL repeat_idle: busy=%b in_ready=%b expected 0 0", bus.busy, bus.in_ready);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.cmd_start = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_job();
        test_input_gaps();
        test_backpressure();
        test_lost_done();
        test_cmd_repeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
